// File: rtl/dma_cmd_queue.sv
// dma_cmd_queue: descriptor FIFO that issues copy commands to dma one at a time and returns tagged status.
module dma_cmd_queue #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [63:0]      cmd_src_addr,
  input  logic [63:0]      cmd_dst_addr,
  input  logic [31:0]      cmd_len,
  input  logic [TAG_W-1:0] cmd_tag,
  input  logic             cmd_src_res,
  input  logic             cmd_dst_res,
  output logic             dma_start,
  output logic [63:0]      dma_src_addr,
  output logic [63:0]      dma_dst_addr,
  output logic [31:0]      dma_len,
  output logic             dma_src_res,
  output logic             dma_dst_res,
  input  logic             dma_done,
  output logic             cpl_valid,
  input  logic             cpl_ready,
  output logic [TAG_W-1:0] cpl_tag,
  output logic [1:0]       cpl_status,
  output logic             busy,
  output logic             halted
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, ISSUE, ARM, WAIT, CPL} state_t;
  typedef struct packed {
    logic [63:0]      src;
    logic [63:0]      dst;
    logic [31:0]      len;
    logic [TAG_W-1:0] tag;
    logic             sr;
    logic             dr;
  } cmd_t;
  state_t        state;
  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [TW-1:0] timer;
  logic          push, pop;
  assign cmd_ready = count != (AW+1)'(DEPTH) && !halted;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = state == IDLE && count != '0 && !halted;
  assign head      = mem[rd_ptr];
  assign busy      = state != IDLE || count != '0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= '{cmd_src_addr, cmd_dst_addr, cmd_len, cmd_tag, cmd_src_res, cmd_dst_res};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      timer        <= '0;
      dma_start    <= 1'b0;
      dma_src_addr <= '0;
      dma_dst_addr <= '0;
      dma_len      <= '0;
      dma_src_res  <= 1'b0;
      dma_dst_res  <= 1'b0;
      cpl_valid    <= 1'b0;
      cpl_tag      <= '0;
      cpl_status   <= 2'b00;
      halted       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop) count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
      dma_start <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          cpl_tag <= head.tag;
          if (head.sr && head.dr) begin
            dma_src_addr <= head.src;
            dma_dst_addr <= head.dst;
            dma_len      <= head.len;
            dma_src_res  <= head.sr;
            dma_dst_res  <= head.dr;
            dma_start    <= 1'b1;
            state        <= ISSUE;
          end else begin
            cpl_status <= 2'b01;
            cpl_valid  <= 1'b1;
            state      <= CPL;
          end
        end
        ISSUE: state <= ARM;
        // dma clears its sticky done on the start edge, so done is not trusted until WAIT
        ARM: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: if (dma_done) begin
          cpl_status <= 2'b00;
          cpl_valid  <= 1'b1;
          state      <= CPL;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          cpl_status <= 2'b10;
          cpl_valid  <= 1'b1;
          halted     <= 1'b1;
          state      <= CPL;
        end else timer <= timer + TW'(1);
        CPL: if (cpl_ready) begin
          cpl_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_cmd_queue.sv
// tb_dma_cmd_queue: directed checks of dma_cmd_queue against a simple sticky-done dma model.
module tb_dma_cmd_queue;
  logic        clk = 0, rst_n = 0;
  logic        cmd_valid = 0, cmd_ready;
  logic [63:0] cmd_src_addr = 0, cmd_dst_addr = 0;
  logic [31:0] cmd_len = 0;
  logic [7:0]  cmd_tag = 0;
  logic        cmd_src_res = 0, cmd_dst_res = 0;
  logic        dma_start;
  logic [63:0] dma_src_addr, dma_dst_addr;
  logic [31:0] dma_len;
  logic        dma_src_res, dma_dst_res, dma_done;
  logic        cpl_valid, cpl_ready = 0;
  logic [7:0]  cpl_tag;
  logic [1:0]  cpl_status;
  logic        busy, halted;
  logic        man = 0, man_done = 0, mdl_done, mdl_busy;
  int          dma_lat = 1, mdl_cnt;
  int          n_chk = 0, n_err = 0, n, s0;
  int          cyc_n = 0, starts = 0, last_start = -1, min_gap = 1000;

  dma_cmd_queue #(.DEPTH(4), .TAG_W(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src_addr(cmd_src_addr), .cmd_dst_addr(cmd_dst_addr), .cmd_len(cmd_len),
    .cmd_tag(cmd_tag), .cmd_src_res(cmd_src_res), .cmd_dst_res(cmd_dst_res),
    .dma_start(dma_start), .dma_src_addr(dma_src_addr), .dma_dst_addr(dma_dst_addr),
    .dma_len(dma_len), .dma_src_res(dma_src_res), .dma_dst_res(dma_dst_res),
    .dma_done(dma_done), .cpl_valid(cpl_valid), .cpl_ready(cpl_ready),
    .cpl_tag(cpl_tag), .cpl_status(cpl_status), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;
  assign dma_done = man ? man_done : mdl_done;

  // dma model: done rises dma_lat cycles after the start edge and stays high until the next start
  always @(posedge clk) begin
    if (!rst_n) begin
      mdl_done <= 0;
      mdl_busy <= 0;
      mdl_cnt  <= 0;
    end else if (dma_start) begin
      mdl_done <= 0;
      mdl_busy <= 1;
      mdl_cnt  <= dma_lat;
    end else if (mdl_busy) begin
      if (mdl_cnt <= 1) begin
        mdl_done <= 1;
        mdl_busy <= 0;
      end else mdl_cnt <= mdl_cnt - 1;
    end
  end

  always @(negedge clk) begin
    cyc_n++;
    if (dma_start) begin
      if (last_start >= 0 && cyc_n - last_start < min_gap) min_gap = cyc_n - last_start;
      last_start = cyc_n;
      starts++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [63:0] s, input logic [63:0] d, input logic [31:0] l,
                      input logic [7:0] t, input logic sr, input logic dr);
    int w = 0;
    cmd_valid = 1; cmd_src_addr = s; cmd_dst_addr = d; cmd_len = l;
    cmd_tag = t; cmd_src_res = sr; cmd_dst_res = dr;
    while (!cmd_ready && w < 100) begin @(negedge clk); w++; end
    if (w >= 100) chk("push_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic wait_cpl(output int c);
    c = 0;
    while (!cpl_valid && c < 100) begin @(negedge clk); c++; end
    chk("cpl_seen", cpl_valid, 1);
  endtask

  task automatic wait_start(output int c);
    c = 0;
    while (!dma_start && c < 100) begin @(negedge clk); c++; end
    chk("start_seen", dma_start, 1);
  endtask

  task automatic take(input logic [7:0] t, input logic [1:0] st);
    chk("cpl_tag", cpl_tag, t);
    chk("cpl_status", cpl_status, st);
    cpl_ready = 1;
    @(negedge clk);
    cpl_ready = 0;
    chk("cpl_drop", cpl_valid, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_start", dma_start, 0);
    chk("rst_cpl_valid", cpl_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_src", dma_src_addr, 0);
    rst_n = 1;
    @(negedge clk);

    // single command, dma done 6 cycles after start
    dma_lat = 6;
    s0 = starts;
    push(64'h100, 64'h200, 4, 8'h11, 1, 1);
    wait_cpl(n);
    chk("t1_starts", starts - s0, 1);
    chk("t1_src", dma_src_addr, 64'h100);
    chk("t1_dst", dma_dst_addr, 64'h200);
    chk("t1_len", dma_len, 4);
    chk("t1_res", {dma_src_res, dma_dst_res}, 2'b11);
    take(8'h11, 2'b00);

    // non-resident completes locally, then blocks the queue so it fills
    dma_lat = 1;
    s0 = starts;
    push(64'h300, 64'h400, 2, 8'h22, 1, 0);
    wait_cpl(n);
    chk("t3_cpl_latency_le2", n <= 2, 1);
    for (int i = 1; i <= 4; i++) push(64'h1000 * i, 64'h2000 * i, i, 8'(i), 1, 1);
    chk("t2_full", cmd_ready, 0);
    chk("t3_no_start", starts - s0, 0);
    fork
      push(64'h5000, 64'h6000, 5, 8'h05, 1, 1);
      begin
        repeat (3) @(negedge clk);
        chk("t2_stall", cmd_ready, 0);
        chk("t3_tag", cpl_tag, 8'h22);
        chk("t3_status", cpl_status, 2'b01);
        cpl_ready = 1;
      end
    join
    for (int i = 1; i <= 5; i++) begin
      wait_cpl(n);
      take(8'(i), 2'b00);
    end
    chk("t2_starts", starts - s0, 5);

    // completion held back with a second command queued (len=0)
    push(64'h10, 64'h20, 8, 8'h31, 1, 1);
    push(64'h30, 64'h40, 0, 8'h32, 1, 1);
    wait_cpl(n);
    s0 = starts;
    repeat (10) @(negedge clk);
    chk("t5_valid_held", cpl_valid, 1);
    chk("t5_tag_held", cpl_tag, 8'h31);
    chk("t5_no_start", starts - s0, 0);
    chk("t5_busy", busy, 1);
    take(8'h31, 2'b00);
    wait_cpl(n);
    chk("t5_len0", dma_len, 0);
    take(8'h32, 2'b00);

    // stale done high through ISSUE/ARM, then real done in WAIT
    man = 1; man_done = 1;
    push(64'h700, 64'h800, 3, 8'h41, 1, 1);
    wait_start(n);
    @(negedge clk);
    chk("t6_arm_no_cpl", cpl_valid, 0);
    @(negedge clk);
    man_done = 0;
    chk("t6_wait_no_cpl", cpl_valid, 0);
    repeat (3) @(negedge clk);
    chk("t6_still_wait", cpl_valid, 0);
    man_done = 1;
    wait_cpl(n);
    chk("t6_done_latency", n, 1);
    take(8'h41, 2'b00);
    man_done = 0;
    push(64'h900, 64'hA00, 3, 8'h42, 1, 1);
    push(64'hB00, 64'hC00, 3, 8'h43, 1, 1);
    wait_start(n);
    repeat (4) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("t6_rst_cmd_ready", cmd_ready, 1);
    chk("t6_rst_start", dma_start, 0);
    chk("t6_rst_src", dma_src_addr, 0);
    chk("t6_rst_len", dma_len, 0);
    chk("t6_rst_cpl", {cpl_valid, cpl_tag, cpl_status}, 0);
    chk("t6_rst_busy", busy, 0);
    rst_n = 1;
    @(negedge clk);

    // timeout with dma silent: halts and freezes queue
    push(64'hD00, 64'hE00, 3, 8'h51, 1, 1);
    push(64'hF00, 64'hF80, 3, 8'h52, 1, 1);
    wait_start(n);
    wait_cpl(n);
    chk("t4_timeout_cycles", n, 18);
    chk("t4_halted", halted, 1);
    chk("t4_cmd_ready", cmd_ready, 0);
    take(8'h51, 2'b10);
    s0 = starts;
    repeat (20) @(negedge clk);
    chk("t4_no_start", starts - s0, 0);
    chk("t4_no_cpl", cpl_valid, 0);
    chk("t4_still_halted", halted, 1);
    chk("t4_busy_kept", busy, 1);
    rst_n = 0;
    @(negedge clk);
    chk("t4_rst_halted", halted, 0);
    chk("t4_rst_ready", cmd_ready, 1);
    chk("t4_rst_busy", busy, 0);
    rst_n = 1; man = 0;
    @(negedge clk);
    push(64'h1234, 64'h5678, 7, 8'h61, 1, 1);
    wait_cpl(n);
    take(8'h61, 2'b00);
    chk("min_start_gap", min_gap, 5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
